// File: rtl/multi_freq_divider.sv
// multi_freq_divider: multi-channel programmable clock divider / tick generator.
// Each channel counts clk_in edges up to a runtime terminal count (tc). It emits a
// one-cycle tick at each wrap and an optional 50%-duty divided clock.
//
// Ports:
//   clk_in   - single rising-edge clock
//   rst_n    - asynchronous active-low reset
//   en       - per-channel count enable
//   mode     - per channel: 0 = clk_out toggles on wrap, 1 = tick only (clk_out held 0)
//   sync     - clears every counter and clk_out so that the channels are phase aligned
//   div_wr   - one-cycle strobe that loads div_val into the tc of channel div_sel
//   div_sel  - target channel of div_wr (values >= NUM_CH are ignored)
//   div_val  - new terminal count; the period becomes div_val+1 cycles
//   tick     - registered one-cycle pulse at each terminal count
//   clk_out  - registered divided clock, period 2*(tc+1) cycles in mode 0
module multi_freq_divider #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned DEFAULT_TC = 9999,
  parameter int unsigned SEL_W      = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CNT_W-1:0] RESET_TC = CNT_W'(DEFAULT_TC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  tc_q  [NUM_CH];
  logic [CNT_W-1:0]  tc_d  [NUM_CH];
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] clk_d;

  // Next-state for every channel: sync > enable hold > wrap > shrink guard > count.
  always_comb begin
    tick_d = '0;
    clk_d  = clk_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      tc_d[i]  = tc_q[i];

      // tc loads independently of sync/en; the compare below still sees the old tc.
      if (div_wr && (div_sel == SEL_W'(i))) begin
        tc_d[i] = div_val;
      end

      if (sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (en[i]) begin
        if (cnt_q[i] == tc_q[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          clk_d[i]  = ~clk_q[i];
        end else if (cnt_q[i] > tc_q[i]) begin
          // tc was shrunk below the running count: restart silently instead of wrapping.
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end

      if (mode[i]) begin
        clk_d[i] = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      clk_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        tc_q[i]  <= RESET_TC;
      end
    end else begin
      tick_q <= tick_d;
      clk_q  <= clk_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        tc_q[i]  <= tc_d[i];
      end
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;

endmodule
